// File: rtl/cam_udp_packetizer_if.sv
// rtl/cam_udp_packetizer_if.sv - camera word input, UDP app stream output and status bundle
interface cam_udp_packetizer_if #(
    parameter int BUF_DEPTH = 512
);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [31:0]      cam_data;
    logic             cam_data_valid;
    logic             udp_tx_ready;
    logic             app_tx_req;
    logic             app_tx_ack;
    logic [7:0]       app_data;
    logic             app_valid;
    logic             app_last;
    logic [15:0]      app_length;
    logic [15:0]      app_port;
    logic             ovf_clr;
    logic             overflow;
    logic [CNT_W-1:0] buf_count;

    modport master (
        input  cam_data, cam_data_valid, udp_tx_ready, app_tx_ack, ovf_clr,
        output app_tx_req, app_data, app_valid, app_last, app_length, app_port,
               overflow, buf_count
    );

    modport slave (
        output cam_data, cam_data_valid, udp_tx_ready, app_tx_ack, ovf_clr,
        input  app_tx_req, app_data, app_valid, app_last, app_length, app_port,
               overflow, buf_count
    );
endinterface

// File: rtl/cam_udp_packetizer.sv
// rtl/cam_udp_packetizer.sv - buffers 32-bit camera words and streams them MSB-first as fixed-size UDP payloads
module cam_udp_packetizer #(
    parameter int          PKT_WORDS  = 256,
    parameter int          BUF_DEPTH  = 512,
    parameter logic [15:0] APP_PORT   = 16'd8080,
    parameter int          GAP_CYCLES = 12
) (
    input logic                  clk,
    input logic                  rst_n,
    cam_udp_packetizer_if.master bus
);
    localparam int                PTR_W     = $clog2(BUF_DEPTH);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0]  PKT_CNT   = CNT_W'(PKT_WORDS);
    localparam logic [13:0]       LAST_WORD = 14'(PKT_WORDS - 1);
    localparam logic [15:0]       LAST_GAP  = 16'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, SEND, GAP} state_t;

    state_t           state, state_nxt;
    logic [31:0]      mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [13:0]      word_cnt;
    logic [1:0]       byte_idx;
    logic [15:0]      gap_cnt;
    logic             ovf_q;
    logic             buf_full, wr_en, drop, pop, last_byte;
    logic [31:0]      rd_word;
    logic [7:0]       byte_sel;
    logic             req_o, valid_o, last_o;
    logic [7:0]       data_o;

    assign buf_full  = (count == DEPTH_CNT);
    assign wr_en     = bus.cam_data_valid && !buf_full;
    assign drop      = bus.cam_data_valid && buf_full;
    assign pop       = (state == SEND) && (byte_idx == 2'd3);
    assign last_byte = pop && (word_cnt == LAST_WORD);
    assign rd_word   = mem[rd_ptr];

    // Word storage; contents need no reset since readers are gated by count and state
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.cam_data;
        end
    end

    // Pointers, occupancy and sticky overflow; a drop in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)             ovf_q <= 1'b1;
            else if (bus.ovf_clr) ovf_q <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Byte-within-word and word-within-packet position, only advancing while sending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= 2'd0;
            word_cnt <= '0;
        end else if (state == SEND) begin
            byte_idx <= byte_idx + 2'd1;
            if (pop) word_cnt <= last_byte ? 14'd0 : word_cnt + 14'd1;
        end else begin
            byte_idx <= 2'd0;
            word_cnt <= '0;
        end
    end

    // Inter-packet gap timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              gap_cnt <= '0;
        else if (state == GAP)   gap_cnt <= gap_cnt + 16'd1;
        else                     gap_cnt <= '0;
    end

    // Big-endian byte select from the word at the head of the buffer
    always_comb begin
        byte_sel = 8'd0;
        case (byte_idx)
            2'd0:    byte_sel = rd_word[31:24];
            2'd1:    byte_sel = rd_word[23:16];
            2'd2:    byte_sel = rd_word[15:8];
            default: byte_sel = rd_word[7:0];
        endcase
    end

    // Next-state and stream outputs; everything is decoded from registered state so reset clears it at once
    always_comb begin
        state_nxt = state;
        req_o     = 1'b0;
        valid_o   = 1'b0;
        last_o    = 1'b0;
        data_o    = 8'd0;
        case (state)
            IDLE: begin
                if (count >= PKT_CNT && bus.udp_tx_ready) state_nxt = REQ;
            end
            REQ: begin
                req_o = 1'b1;
                if (bus.app_tx_ack) state_nxt = SEND;
            end
            SEND: begin
                valid_o = 1'b1;
                data_o  = byte_sel;
                last_o  = last_byte;
                if (last_byte) state_nxt = GAP;
            end
            GAP: begin
                if (gap_cnt == LAST_GAP) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.app_tx_req = req_o;
    assign bus.app_valid  = valid_o;
    assign bus.app_data   = data_o;
    assign bus.app_last   = last_o;
    assign bus.app_length = 16'(PKT_WORDS * 4);
    assign bus.app_port   = APP_PORT;
    assign bus.overflow   = ovf_q;
    assign bus.buf_count  = count;
endmodule

// File: tb/tb_cam_udp_packetizer.sv
// tb/tb_cam_udp_packetizer.sv - directed-vector self-checking bench for cam_udp_packetizer
module tb_cam_udp_packetizer;
    localparam int PKT_WORDS  = 4;
    localparam int BUF_DEPTH  = 8;
    localparam int GAP_CYCLES = 12;
    localparam int NBYTES     = PKT_WORDS * 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cam_udp_packetizer_if #(.BUF_DEPTH(BUF_DEPTH)) bus ();

    cam_udp_packetizer #(
        .PKT_WORDS (PKT_WORDS),
        .BUF_DEPTH (BUF_DEPTH),
        .APP_PORT  (16'd8080),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic        cv;
        logic [31:0] cd;
        logic        ack;
        logic        req;
        logic        vld;
        logic [7:0]  dat;
        logic        lst;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vt [22];

    function automatic logic [31:0] mkword(input logic [7:0] base, input int i);
        logic [7:0] b;
        b = base + 8'(4 * i);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    function automatic logic [63:0] outs();
        return 64'({bus.app_tx_req, bus.app_valid, bus.app_data, bus.app_last,
                    bus.overflow, bus.buf_count});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.cam_data       = '0;
        bus.cam_data_valid = 1'b0;
        bus.udp_tx_ready   = 1'b0;
        bus.app_tx_ack     = 1'b0;
        bus.ovf_clr        = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w);
        bus.cam_data       = w;
        bus.cam_data_valid = 1'b1;
        @(negedge clk);
        bus.cam_data_valid = 1'b0;
        bus.cam_data       = '0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!bus.app_tx_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(bus.app_tx_req), 64'd1);
    endtask

    task automatic recv_bytes(input string name, input logic [7:0] base);
        for (int k = 0; k < NBYTES; k++) begin
            check($sformatf("%s_b%0d", name, k),
                  64'({bus.app_valid, bus.app_data, bus.app_last}),
                  64'({1'b1, base + 8'(k), (k == NBYTES - 1)}));
            @(negedge clk);
        end
        check({name, "_end"}, 64'({bus.app_valid, bus.app_data}), 64'd0);
    endtask

    task automatic recv_packet(input string name, input logic [7:0] base);
        wait_req({name, "_req"});
        bus.app_tx_ack = 1'b1;
        @(negedge clk);
        bus.app_tx_ack = 1'b0;
        recv_bytes(name, base);
    endtask

    initial begin
        int seen;
        int nw, beats, cnt_exp, wr_prev, pop_prev, last_cyc, req2, prev_req;
        logic wr;

        bus.cam_data       = '0;
        bus.cam_data_valid = 1'b0;
        bus.udp_tx_ready   = 1'b0;
        bus.app_tx_ack     = 1'b0;
        bus.ovf_clr        = 1'b0;
        rst_n = 1'b0;
        #12;
        check("reset_outs", outs(), 64'd0);
        check("reset_len_port", 64'({bus.app_length, bus.app_port}), 64'({16'd16, 16'd8080}));

        for (int r = 0; r < 4; r++)
            vt[r] = '{1'b1, mkword(8'h01, r), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'(r + 1)};
        vt[4] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd4};
        for (int i = 0; i < 16; i++)
            vt[5 + i] = '{1'b0, 32'h0, (i == 0), 1'b0, 1'b1, 8'(i + 1), (i == 15), 4'(4 - i / 4)};
        vt[21] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0};

        do_reset();
        bus.udp_tx_ready = 1'b1;
        for (int r = 0; r < 22; r++) begin
            bus.cam_data_valid = vt[r].cv;
            bus.cam_data       = vt[r].cd;
            bus.app_tx_ack     = vt[r].ack;
            @(negedge clk);
            check($sformatf("vec%0d", r),
                  64'({bus.app_tx_req, bus.app_valid, bus.app_data, bus.app_last, bus.buf_count}),
                  64'({vt[r].req, vt[r].vld, vt[r].dat, vt[r].lst, vt[r].cnt}));
        end
        bus.cam_data_valid = 1'b0;
        bus.app_tx_ack     = 1'b0;

        do_reset();
        bus.udp_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(mkword(8'h20, i));
        seen = 0;
        repeat (30) begin
            if (bus.app_tx_req) seen = 1;
            @(negedge clk);
        end
        check("short_no_req", 64'(seen), 64'd0);
        check("short_count", 64'(bus.buf_count), 64'd3);

        do_reset();
        for (int i = 0; i < 9; i++) push(mkword(8'h80, i));
        check("ovf_count", 64'(bus.buf_count), 64'd8);
        check("ovf_flag", 64'(bus.overflow), 64'd1);
        bus.ovf_clr = 1'b1;
        push(mkword(8'h80, 9));
        bus.ovf_clr = 1'b0;
        check("ovf_clr_with_drop", 64'(bus.overflow), 64'd1);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        check("ovf_cleared", 64'({bus.overflow, bus.buf_count}), 64'({1'b0, 4'd8}));
        bus.udp_tx_ready = 1'b1;
        recv_packet("ovf_pkt0", 8'h80);
        recv_packet("ovf_pkt1", 8'h90);
        seen = 0;
        repeat (30) begin
            if (bus.app_tx_req) seen = 1;
            @(negedge clk);
        end
        check("ovf_no_third", 64'({seen[0], bus.buf_count}), 64'd0);

        do_reset();
        bus.udp_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(mkword(8'h30, i));
        wait_req("dly_req");
        bus.udp_tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("dly_hold%0d", i), 64'({bus.app_tx_req, bus.app_valid}), 64'd2);
        end
        bus.app_tx_ack = 1'b1;
        @(negedge clk);
        bus.app_tx_ack = 1'b0;
        recv_bytes("dly", 8'h30);

        do_reset();
        bus.udp_tx_ready = 1'b1;
        nw = 0; beats = 0; cnt_exp = 0; wr_prev = 0; pop_prev = 0;
        last_cyc = -1; req2 = -1; prev_req = 0;
        for (int c = 0; c < 100 && beats < 2 * NBYTES; c++) begin
            cnt_exp = cnt_exp + wr_prev - pop_prev;
            check($sformatf("sim_cnt%0d", c), 64'(bus.buf_count), 64'(cnt_exp));
            pop_prev = 0;
            if (bus.app_valid) begin
                check($sformatf("sim_byte%0d", beats),
                      64'({bus.app_data, bus.app_last}),
                      64'({8'h40 + 8'(beats), (beats == NBYTES - 1 || beats == 2 * NBYTES - 1)}));
                pop_prev = (beats % 4 == 3) ? 1 : 0;
                if (beats == NBYTES - 1) last_cyc = c;
                beats++;
            end
            if (bus.app_tx_req && prev_req == 0 && last_cyc >= 0 && req2 < 0) req2 = c;
            prev_req = bus.app_tx_req ? 1 : 0;
            bus.app_tx_ack = bus.app_tx_req;
            wr = (c < 4) || (c % 2 == 1 && nw < 10);
            bus.cam_data_valid = wr;
            bus.cam_data = wr ? mkword(8'h40, nw) : 32'h0;
            if (wr) nw++;
            wr_prev = wr ? 1 : 0;
            @(negedge clk);
        end
        bus.cam_data_valid = 1'b0;
        bus.app_tx_ack     = 1'b0;
        check("sim_beats", 64'(beats), 64'(2 * NBYTES));
        check("sim_gap", 64'(req2 - last_cyc), 64'(GAP_CYCLES + 2));
        check("sim_final", 64'({bus.overflow, bus.buf_count}), 64'({1'b0, 4'd2}));

        do_reset();
        bus.udp_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(mkword(8'h01, i));
        wait_req("mid_req");
        bus.app_tx_ack = 1'b1;
        @(negedge clk);
        bus.app_tx_ack = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_byte6", 64'({bus.app_valid, bus.app_data}), 64'({1'b1, 8'h06}));
        #2 rst_n = 1'b0;
        #1;
        check("mid_async_zero", outs(), 64'd0);
        check("mid_len_port", 64'({bus.app_length, bus.app_port}), 64'({16'd16, 16'd8080}));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_after_release", outs(), 64'd0);
        for (int i = 0; i < 4; i++) push(mkword(8'hC0, i));
        recv_packet("mid_new", 8'hC0);
        check("mid_final_count", 64'(bus.buf_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
